// File: rtl/vm_pkg.sv
// Shared vending-machine encodings: coin selects, denomination values, error codes, payout states.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_1    = 2'b11;

    localparam int unsigned DENOM_10 = 10;
    localparam int unsigned DENOM_5  = 5;
    localparam int unsigned DENOM_1  = 1;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_NOCHG = 2'b01;
    localparam logic [1:0] ERR_JAM   = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StFire,
        StWaitAck,
        StDone,
        StFault
    } pay_state_e;

endpackage

// File: rtl/change_denom_pick.sv
// Greedy coin choice: largest denomination that fits the amount owed and whose hopper is not empty.
module change_denom_pick
    import vm_pkg::*;
#(
    parameter int unsigned AMT_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       hop_empty,
    output logic             found,
    output logic [1:0]       coin_sel,
    output logic [AMT_W-1:0] denom
);

    logic [31:0] rem_ext;
    assign rem_ext = 32'(remaining);

    always_comb begin
        found    = 1'b0;
        coin_sel = COIN_NONE;
        denom    = '0;
        if (rem_ext >= DENOM_10 && !hop_empty[2]) begin
            found    = 1'b1;
            coin_sel = COIN_10;
            denom    = AMT_W'(DENOM_10);
        end else if (rem_ext >= DENOM_5 && !hop_empty[1]) begin
            found    = 1'b1;
            coin_sel = COIN_5;
            denom    = AMT_W'(DENOM_5);
        end else if (rem_ext >= DENOM_1 && !hop_empty[0]) begin
            found    = 1'b1;
            coin_sel = COIN_1;
            denom    = AMT_W'(DENOM_1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: drives the $10/$5/$1 hoppers one coin at a time until the amount is paid.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned AMT_W       = 4,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic [2:0]       hop_empty,
    output logic [1:0]       coin_sel,
    output logic             coin_fire,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] remaining
);

    localparam int unsigned PW = $clog2(PULSE_CYC + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT);

    pay_state_e       state_q;
    logic [1:0]       coin_sel_q;
    logic             coin_fire_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       err_code_q;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] denom_q;
    logic [PW-1:0]    pulse_cnt_q;
    logic [TW-1:0]    to_cnt_q;

    logic             pick_found;
    logic [1:0]       pick_sel;
    logic [AMT_W-1:0] pick_denom;

    change_denom_pick #(
        .AMT_W (AMT_W)
    ) u_pick (
        .remaining (remaining_q),
        .hop_empty (hop_empty),
        .found     (pick_found),
        .coin_sel  (pick_sel),
        .denom     (pick_denom)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            coin_sel_q  <= COIN_NONE;
            coin_fire_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_OK;
            remaining_q <= '0;
            denom_q     <= '0;
            pulse_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        remaining_q <= req_amount;
                        err_code_q  <= ERR_OK;
                        busy_q      <= 1'b1;
                        state_q     <= (req_amount == '0) ? StDone : StSelect;
                    end
                end
                StSelect: begin
                    if (pick_found) begin
                        coin_sel_q  <= pick_sel;
                        denom_q     <= pick_denom;
                        coin_fire_q <= 1'b1;
                        pulse_cnt_q <= PW'(PULSE_CYC - 1);
                        state_q     <= StFire;
                    end else begin
                        err_code_q <= ERR_NOCHG;
                        state_q    <= StFault;
                    end
                end
                StFire: begin
                    // Last pulse cycle: drop the solenoid and start the ack window.
                    if (pulse_cnt_q == '0) begin
                        coin_fire_q <= 1'b0;
                        to_cnt_q    <= '0;
                        state_q     <= StWaitAck;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - PW'(1);
                    end
                end
                StWaitAck: begin
                    if (coin_ack) begin
                        remaining_q <= remaining_q - denom_q;
                        state_q     <= (remaining_q == denom_q) ? StDone : StSelect;
                    end else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_code_q <= ERR_JAM;
                        state_q    <= StFault;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                StDone: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    coin_sel_q <= COIN_NONE;
                    state_q    <= StIdle;
                end
                StFault: begin
                    error_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    coin_sel_q <= COIN_NONE;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign coin_sel  = coin_sel_q;
    assign coin_fire = coin_fire_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payout scenarios plus reset/timing corner sequences.
module tb_change_dispenser;

    localparam int AMT_W   = 4;
    localparam int PULSE   = 4;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic [2:0]       hop_empty;
    logic [1:0]       coin_sel;
    logic             coin_fire;
    logic             coin_ack;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [AMT_W-1:0] remaining;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .PULSE_CYC   (PULSE),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_amount (req_amount),
        .hop_empty  (hop_empty),
        .coin_sel   (coin_sel),
        .coin_fire  (coin_fire),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             amount;
        logic [2:0]     hop_empty;
        int             ack_delay;  // ack in this WAIT_ACK cycle; 0 = never
        int             exp_coins;
        logic [3:0][1:0] exp_sel;
        logic [1:0]     exp_err;
        int             exp_rem;
        bit             exp_done;
    } vec_t;

    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int amt, input logic [2:0] he, input int dly, input int nc,
                                input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                                input logic [1:0] e, input int rem, input bit dn);
        vec_t v;
        v.amount     = amt;
        v.hop_empty  = he;
        v.ack_delay  = dly;
        v.exp_coins  = nc;
        v.exp_sel    = '0;
        v.exp_sel[0] = s0;
        v.exp_sel[1] = s1;
        v.exp_sel[2] = s2;
        v.exp_err    = e;
        v.exp_rem    = rem;
        v.exp_done   = dn;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int              coins    = 0;
        int              fire_len = 0;
        int              wait_cnt = 0;
        int              steps    = 0;
        bit              in_wait  = 0;
        bit              finished = 0;
        logic            prev_fire = 1'b0;
        logic [3:0][1:0] sels = '0;
        string           tag;
        tag = $sformatf("vec%0d", idx);
        req_valid  = 1'b1;
        req_amount = AMT_W'(v.amount);
        hop_empty  = v.hop_empty;
        step();
        req_valid = 1'b0;
        check({tag, " busy after accept"}, int'(busy), 1);
        while (!finished && steps < 400) begin
            coin_ack = 1'b0;
            if (done || error) begin
                finished = 1;
            end else begin
                if (coin_fire) begin
                    if (!prev_fire) begin
                        if (coins < 4) sels[coins] = coin_sel;
                        coins++;
                        fire_len = 0;
                        in_wait  = 0;
                    end
                    fire_len++;
                end else if (prev_fire) begin
                    check({tag, " fire pulse length"}, fire_len, PULSE);
                    in_wait  = 1;
                    wait_cnt = 1;
                end else if (in_wait) begin
                    wait_cnt++;
                end
                if (in_wait && v.ack_delay != 0 && wait_cnt == v.ack_delay) begin
                    coin_ack = 1'b1;
                    in_wait  = 0;
                end
                prev_fire = coin_fire;
                step();
                steps++;
            end
        end
        coin_ack = 1'b0;
        check({tag, " finished in budget"}, int'(finished), 1);
        check({tag, " coin count"}, coins, v.exp_coins);
        for (int i = 0; i < 4; i++) begin
            if (i < v.exp_coins && i < coins)
                check({tag, $sformatf(" coin_sel[%0d]", i)}, int'(sels[i]), int'(v.exp_sel[i]));
        end
        check({tag, " done"}, int'(done), int'(v.exp_done));
        check({tag, " error"}, int'(error), int'(!v.exp_done));
        check({tag, " err_code"}, int'(err_code), int'(v.exp_err));
        check({tag, " remaining"}, int'(remaining), v.exp_rem);
        check({tag, " busy cleared"}, int'(busy), 0);
        check({tag, " coin_sel cleared"}, int'(coin_sel), 0);
        step();
        check({tag, " pulse one cycle"}, int'(done | error), 0);
        check({tag, " req_ready"}, int'(req_ready), 1);
    endtask

    initial begin
        int cnt;
        int err_at;
        bit seen_fire;

        vecs[0]  = mk(15, 3'b000,  2, 2, 2'b10, 2'b01, 2'b00, 2'b00, 0,  1);
        vecs[1]  = mk(10, 3'b100,  2, 2, 2'b01, 2'b01, 2'b00, 2'b00, 0,  1);
        vecs[2]  = mk(3,  3'b001,  2, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3,  0);
        vecs[3]  = mk(5,  3'b000,  0, 1, 2'b01, 2'b00, 2'b00, 2'b10, 5,  0);
        vecs[4]  = mk(0,  3'b000,  2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  1);
        vecs[5]  = mk(7,  3'b000,  1, 3, 2'b01, 2'b11, 2'b11, 2'b00, 0,  1);
        vecs[6]  = mk(12, 3'b010,  3, 3, 2'b10, 2'b11, 2'b11, 2'b00, 0,  1);
        vecs[7]  = mk(9,  3'b011,  2, 0, 2'b00, 2'b00, 2'b00, 2'b01, 9,  0);
        vecs[8]  = mk(6,  3'b001,  2, 1, 2'b01, 2'b00, 2'b00, 2'b01, 1,  0);
        vecs[9]  = mk(1,  3'b000, 64, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0,  1);
        vecs[10] = mk(1,  3'b000, 65, 1, 2'b11, 2'b00, 2'b00, 2'b10, 1,  0);

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_amount = '0;
        hop_empty  = 3'b000;
        coin_ack   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        check("reset req_ready", int'(req_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset coin_fire", int'(coin_fire), 0);
        check("reset coin_sel", int'(coin_sel), 0);
        check("reset done/error", int'(done | error), 0);
        check("reset err_code", int'(err_code), 0);
        check("reset remaining", int'(remaining), 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Zero amount: done two cycles after accept; request while busy is dropped.
        req_valid  = 1'b1;
        req_amount = '0;
        step();
        check("zero: done not yet", int'(done), 0);
        check("zero: busy", int'(busy), 1);
        check("zero: not ready", int'(req_ready), 0);
        req_amount = AMT_W'(7);
        step();
        req_valid = 1'b0;
        check("zero: done pulse", int'(done), 1);
        check("zero: busy dropped", int'(busy), 0);
        check("zero: coin_fire", int'(coin_fire), 0);
        step();
        check("zero: busy request ignored", int'(remaining), 0);
        check("zero: still idle", int'(busy), 0);

        // Jam timing: error pulse follows 64 WAIT_ACK cycles and one FAULT cycle.
        req_valid  = 1'b1;
        req_amount = AMT_W'(5);
        step();
        req_valid = 1'b0;
        cnt = 0;
        while (!(coin_fire == 1'b0 && cnt > 0) && cnt < 50) begin
            if (coin_fire) cnt++;
            else if (cnt == 0 && busy) cnt = 0;
            step();
            if (!busy) cnt = 50;
        end
        err_at = -1;
        for (int k = 0; k < 80 && err_at < 0; k++) begin
            if (error) err_at = k;
            else step();
        end
        check("jam: error offset from WAIT_ACK entry", err_at, TIMEOUT + 1);
        check("jam: err_code", int'(err_code), 2);
        check("jam: remaining", int'(remaining), 5);
        step();

        // Reset mid-FIRE drops the solenoid at once and discards the payout.
        req_valid  = 1'b1;
        req_amount = AMT_W'(15);
        step();
        req_valid = 1'b0;
        seen_fire = 0;
        for (int k = 0; k < 10 && !seen_fire; k++) begin
            if (coin_fire) seen_fire = 1;
            else step();
        end
        check("rst: fire started", int'(seen_fire), 1);
        step();
        check("rst: fire still high", int'(coin_fire), 1);
        reset = 1'b1;
        #1;
        check("rst: coin_fire async drop", int'(coin_fire), 0);
        check("rst: busy async drop", int'(busy), 0);
        step();
        reset = 1'b0;
        step();
        check("rst: req_ready", int'(req_ready), 1);
        check("rst: remaining", int'(remaining), 0);
        check("rst: coin_sel", int'(coin_sel), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
